branch_hazard_unit: RTL and testbench

- Producer-side companion to the ID-stage branch forwarding logic in the 5-stage MIPS pipeline.
- Forwarding can only deliver values already computed. This block detects the cases where a branch or load consumer in ID cannot be served by forwarding.
- In those cases it stalls PC and IF/ID, injects bubbles into ID/EX, and flushes IF/ID on a resolved taken branch.
- A small FSM holds multi-cycle stalls. A saturating counter records total stall cycles for performance analysis.

---
 rtl/branch_hazard_unit_if.sv | 35 +++
 rtl/branch_hazard_unit.sv | 100 ++++++++++
 tb/tb_branch_hazard_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_unit_if.sv
// rtl/branch_hazard_unit_if.sv - pipeline-side bundle for the branch hazard unit
interface branch_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             ID_Branch;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_BranchTaken;
  logic [REG_W-1:0] IDRs;
  logic [REG_W-1:0] IDRt;
  logic             IDEX_RegWrite;
  logic             IDEX_MemRead;
  logic [REG_W-1:0] IDEXRd;
  logic             EXMEM_MemRead;
  logic [REG_W-1:0] EXMEMRd;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             Stalling;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Branch, ID_UsesRs, ID_UsesRt, ID_BranchTaken, IDRs, IDRt,
           IDEX_RegWrite, IDEX_MemRead, IDEXRd, EXMEM_MemRead, EXMEMRd,
    input  PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling, StallCount
  );

  modport slave (
    input  ID_Branch, ID_UsesRs, ID_UsesRt, ID_BranchTaken, IDRs, IDRt,
           IDEX_RegWrite, IDEX_MemRead, IDEXRd, EXMEM_MemRead, EXMEMRd,
    output PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling, StallCount
  );
endinterface

// File: rtl/branch_hazard_unit.sv
// rtl/branch_hazard_unit.sv - ID-stage stall/flush control for hazards forwarding cannot cover
module branch_hazard_unit #(
  parameter int REG_W              = 5,
  parameter int LOAD_BRANCH_STALLS = 2,
  parameter int CNT_W              = 32
) (
  input logic                 clk,
  input logic                 reset,
  branch_hazard_unit_if.slave hz
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0]       LB_NEED = 2'(LOAD_BRANCH_STALLS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       rs_used, rt_used;
  logic       ex_match, mem_match;
  logic [1:0] need;
  logic       stall;

  always_comb begin
    // Branches compare both operands, so both count as read.
    rs_used   = hz.ID_Branch | hz.ID_UsesRs;
    rt_used   = hz.ID_Branch | hz.ID_UsesRt;
    ex_match  = (hz.IDEXRd != '0) &&
                ((rs_used && (hz.IDEXRd == hz.IDRs)) || (rt_used && (hz.IDEXRd == hz.IDRt)));
    mem_match = (hz.EXMEMRd != '0) &&
                ((rs_used && (hz.EXMEMRd == hz.IDRs)) || (rt_used && (hz.EXMEMRd == hz.IDRt)));

    need = 2'd0;
    if (hz.ID_Branch && hz.IDEX_MemRead && ex_match) begin
      need = LB_NEED;
    end else if (hz.ID_Branch && hz.IDEX_RegWrite && !hz.IDEX_MemRead && ex_match) begin
      need = 2'd1;
    end else if (hz.ID_Branch && hz.EXMEM_MemRead && mem_match) begin
      need = 2'd1;
    end else if (!hz.ID_Branch && hz.IDEX_MemRead && ex_match) begin
      need = 2'd1;
    end

    stall = !reset && ((state_q == HOLD) || (need != 2'd0));

    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      RUN: begin
        if (need > 2'd1) begin
          state_d     = HOLD;
          remaining_d = need - 2'd1;
        end
      end
      HOLD: begin
        if (remaining_q <= 2'd1) begin
          state_d     = RUN;
          remaining_d = 2'd0;
        end else begin
          remaining_d = remaining_q - 2'd1;
        end
      end
      default: begin
        state_d     = RUN;
        remaining_d = 2'd0;
      end
    endcase

    count_d = count_q;
    if (stall && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      remaining_q <= 2'd0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  assign hz.PCWrite     = !stall;
  assign hz.IFIDWrite   = !stall;
  assign hz.IDEX_Bubble = stall;
  assign hz.Stalling    = stall;
  assign hz.IFID_Flush  = !reset && !stall && hz.ID_Branch && hz.ID_BranchTaken;
  assign hz.StallCount  = count_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb/tb_branch_hazard_unit.sv - randomized and directed checks against a behavioural model
module tb_branch_hazard_unit;
  localparam int LBS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_hazard_unit_if #(.REG_W(5), .CNT_W(32)) bus ();
  branch_hazard_unit_if #(.REG_W(5), .CNT_W(4))  bus4 ();

  assign bus4.ID_Branch      = bus.ID_Branch;
  assign bus4.ID_UsesRs      = bus.ID_UsesRs;
  assign bus4.ID_UsesRt      = bus.ID_UsesRt;
  assign bus4.ID_BranchTaken = bus.ID_BranchTaken;
  assign bus4.IDRs           = bus.IDRs;
  assign bus4.IDRt           = bus.IDRt;
  assign bus4.IDEX_RegWrite  = bus.IDEX_RegWrite;
  assign bus4.IDEX_MemRead   = bus.IDEX_MemRead;
  assign bus4.IDEXRd         = bus.IDEXRd;
  assign bus4.EXMEM_MemRead  = bus.EXMEM_MemRead;
  assign bus4.EXMEMRd        = bus.EXMEMRd;

  branch_hazard_unit #(.REG_W(5), .LOAD_BRANCH_STALLS(LBS), .CNT_W(32)) dut (
    .clk(clk), .reset(rst), .hz(bus.slave)
  );
  branch_hazard_unit #(.REG_W(5), .LOAD_BRANCH_STALLS(LBS), .CNT_W(4)) dut4 (
    .clk(clk), .reset(rst), .hz(bus4.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model state: stall cycles still owed, and the two counters.
  int     m_hold = 0;
  longint m_cnt  = 0;
  int     m_cnt4 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] rd);
    bit rs_use, rt_use;
    rs_use = bus.ID_Branch || bus.ID_UsesRs;
    rt_use = bus.ID_Branch || bus.ID_UsesRt;
    if (rd == 0) return 0;
    return (rs_use && rd == bus.IDRs) || (rt_use && rd == bus.IDRt);
  endfunction

  function automatic int model_need();
    bit br;
    br = bus.ID_Branch;
    if (br && bus.IDEX_MemRead && reads(bus.IDEXRd)) return LBS;
    if (br && bus.IDEX_RegWrite && !bus.IDEX_MemRead && reads(bus.IDEXRd)) return 1;
    if (br && bus.EXMEM_MemRead && reads(bus.EXMEMRd)) return 1;
    if (!br && bus.IDEX_MemRead && reads(bus.IDEXRd)) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    bus.ID_Branch = 0; bus.ID_UsesRs = 0; bus.ID_UsesRt = 0; bus.ID_BranchTaken = 0;
    bus.IDRs = 0; bus.IDRt = 0; bus.IDEX_RegWrite = 0; bus.IDEX_MemRead = 0;
    bus.IDEXRd = 0; bus.EXMEM_MemRead = 0; bus.EXMEMRd = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    int need;
    bit s, f;
    need = 0;
    #1;
    if (rst) begin
      s = 0;
    end else if (m_hold > 0) begin
      s = 1;
    end else begin
      need = model_need();
      s = (need > 0);
    end
    f = !rst && !s && bus.ID_Branch && bus.ID_BranchTaken;
    check(tag, {27'd0, bus.PCWrite, bus.IFIDWrite, bus.IDEX_Bubble, bus.IFID_Flush, bus.Stalling},
          {27'd0, !s, !s, s, f, s});
    check({tag, "_cnt"}, bus.StallCount, 32'(m_cnt));
    check({tag, "_cnt4"}, {28'd0, bus4.StallCount}, 32'(m_cnt4));
    check({tag, "_ctl4"}, {31'd0, bus4.Stalling}, {31'd0, s});
    @(posedge clk);
    if (rst) begin
      m_hold = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (s) begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_hold > 0) m_hold--;
      else if (need > 1) m_hold = need - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    rst = 1;
    cycle("reset");
    cycle("reset2");
    rst = 0;

    // Load feeding a branch: two stall cycles, then free.
    bus.IDEX_MemRead = 1; bus.IDEXRd = 8; bus.ID_Branch = 1; bus.IDRs = 8;
    cycle("ldbr_s1");
    cycle("ldbr_s2");
    clear_inputs(); bus.ID_Branch = 1; bus.IDRs = 8;
    cycle("ldbr_run");
    check("ldbr_count", bus.StallCount, 32'd2);

    // ALU result feeding a branch, then taken branch flushes.
    clear_inputs();
    bus.IDEX_RegWrite = 1; bus.IDEXRd = 9; bus.ID_Branch = 1; bus.IDRt = 9; bus.ID_BranchTaken = 1;
    cycle("alubr_s");
    clear_inputs(); bus.ID_Branch = 1; bus.ID_BranchTaken = 1; bus.IDRt = 9;
    cycle("alubr_flush");
    check("flush_seen", {31'd0, bus.IFID_Flush}, 32'd1);

    // Load-use on a non-branch, and the r0 exemption.
    clear_inputs();
    bus.IDEX_MemRead = 1; bus.IDEXRd = 5; bus.ID_UsesRt = 1; bus.IDRt = 5;
    cycle("lduse");
    bus.IDEXRd = 0; bus.IDRt = 0;
    cycle("lduse_r0");

    // Both operands match a load; taken flag must not flush while stalled.
    clear_inputs();
    bus.IDEX_MemRead = 1; bus.IDEXRd = 4; bus.ID_Branch = 1; bus.IDRs = 4; bus.IDRt = 4;
    bus.ID_BranchTaken = 1;
    cycle("dbl_s1");
    cycle("dbl_s2");
    clear_inputs();
    cycle("dbl_run");

    // Reset in the second stall cycle of a branch-on-load.
    bus.IDEX_MemRead = 1; bus.IDEXRd = 7; bus.ID_Branch = 1; bus.IDRt = 7;
    cycle("rsthold_s1");
    rst = 1;
    cycle("rsthold_rst");
    rst = 0;
    clear_inputs();
    cycle("rsthold_after");
    check("rsthold_count", bus.StallCount, 32'd0);

    // Continuous load-use hazard saturates the 4-bit counter.
    bus.IDEX_MemRead = 1; bus.IDEXRd = 3; bus.ID_UsesRs = 1; bus.IDRs = 3;
    for (int i = 0; i < 20; i++) cycle("sat");
    check("sat_count4", {28'd0, bus4.StallCount}, 32'd15);
    clear_inputs();
    cycle("sat_hold");

    // Randomized traffic over a small register space to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.ID_Branch      = 1'($urandom_range(0, 1));
      bus.ID_UsesRs      = 1'($urandom_range(0, 1));
      bus.ID_UsesRt      = 1'($urandom_range(0, 1));
      bus.ID_BranchTaken = 1'($urandom_range(0, 1));
      bus.IDRs           = 5'($urandom_range(0, 3));
      bus.IDRt           = 5'($urandom_range(0, 3));
      bus.IDEX_RegWrite  = 1'($urandom_range(0, 1));
      bus.IDEX_MemRead   = 1'($urandom_range(0, 2) == 0);
      bus.IDEXRd         = 5'($urandom_range(0, 3));
      bus.EXMEM_MemRead  = 1'($urandom_range(0, 2) == 0);
      bus.EXMEMRd        = 5'($urandom_range(0, 3));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
